// File: rtl/damage_arbiter.sv
// damage_arbiter: two-player health tracker fed by four collision sources.
// Each source raises a one-shot hit on a rising edge of its hit bit. A
// round-robin arbiter applies one pending hit per cycle with saturating
// subtraction. The round ends in KO when a player's health reaches zero.
//
// Ports
//   Clk          system clock, rising edge
//   Reset        asynchronous, active-high reset
//   round_start  one-cycle request to begin or restart a round
//   hit[3:0]     per-source collision level
//   hit_tgt[3:0] per-source target (0 = player 1, 1 = player 2)
//   hit_dmg[31:0] per-source 8-bit damage, source i in [8i+7:8i]
//   hp1, hp2     player health
//   hit_ack[3:0] one-hot marker of the source applied this cycle (combinational)
//   phase[1:0]   00 IDLE, 01 ACTIVE, 10 KO
//   winner[1:0]  00 none, 01 player 1, 10 player 2
module damage_arbiter #(
    parameter logic [7:0] HP_INIT = 8'd250
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        round_start,
    input  logic [3:0]  hit,
    input  logic [3:0]  hit_tgt,
    input  logic [31:0] hit_dmg,
    output logic [7:0]  hp1,
    output logic [7:0]  hp2,
    output logic [3:0]  hit_ack,
    output logic [1:0]  phase,
    output logic [1:0]  winner
);

    localparam int unsigned NSRC = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        KO     = 2'b10
    } phase_t;

    phase_t      state;
    logic [3:0]  hit_q;
    logic [3:0]  pending;
    logic [3:0]  slot_tgt;
    logic [7:0]  slot_dmg [NSRC];
    logic [1:0]  rr;

    logic [3:0]  rise;
    logic        arb_en;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic        sel_tgt;
    logic [7:0]  sel_dmg;
    logic [7:0]  tgt_hp;
    logic [7:0]  hp_after;
    logic        ko;
    logic [3:0]  set_mask;
    logic [3:0]  pending_nxt;

    assign phase = state;

    // Round-robin grant, damage preview and next pending mask.
    // round_start suppresses arbitration so a restart never emits an ack.
    always_comb begin
        rise        = hit & ~hit_q;
        arb_en      = (state == ACTIVE) && !round_start;
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr + 2'(k);
            if (arb_en && !grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        hit_ack  = grant_valid ? 4'(4'b0001 << grant_idx) : 4'b0000;
        sel_tgt  = slot_tgt[grant_idx];
        sel_dmg  = slot_dmg[grant_idx];
        tgt_hp   = sel_tgt ? hp2 : hp1;
        hp_after = (tgt_hp > sel_dmg) ? (tgt_hp - sel_dmg) : 8'd0;
        ko       = grant_valid && (hp_after == 8'd0);
        // A new rise is accepted when the slot is free or being granted now,
        // so set wins over the grant's clear.
        set_mask    = rise & (~pending | hit_ack);
        pending_nxt = (pending & ~hit_ack) | set_mask;
    end

    // Round FSM, health and pending-slot state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            hp1      <= HP_INIT;
            hp2      <= HP_INIT;
            winner   <= 2'b00;
            pending  <= 4'b0000;
            hit_q    <= 4'b0000;
            rr       <= 2'd0;
            slot_tgt <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                slot_dmg[i] <= 8'd0;
            end
        end else begin
            hit_q <= hit;
            case (state)
                IDLE, KO: begin
                    if (round_start) begin
                        state   <= ACTIVE;
                        hp1     <= HP_INIT;
                        hp2     <= HP_INIT;
                        winner  <= 2'b00;
                        pending <= 4'b0000;
                        rr      <= 2'd0;
                    end
                end
                ACTIVE: begin
                    if (round_start) begin
                        hp1     <= HP_INIT;
                        hp2     <= HP_INIT;
                        winner  <= 2'b00;
                        pending <= 4'b0000;
                        rr      <= 2'd0;
                    end else begin
                        pending <= pending_nxt;
                        for (int i = 0; i < 4; i++) begin
                            if (set_mask[i]) begin
                                slot_tgt[i] <= hit_tgt[i];
                                slot_dmg[i] <= hit_dmg[8*i +: 8];
                            end
                        end
                        if (grant_valid) begin
                            rr <= grant_idx + 2'd1;
                            if (sel_tgt) begin
                                hp2 <= hp_after;
                            end else begin
                                hp1 <= hp_after;
                            end
                            if (ko) begin
                                state   <= KO;
                                winner  <= sel_tgt ? 2'b01 : 2'b10;
                                pending <= 4'b0000;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_damage_arbiter.sv
// Testbench for damage_arbiter: directed round scenarios followed by random
// traffic, compared against a behavioural model of the round rules.
module tb_damage_arbiter;

    localparam int HP = 250;

    logic        Clk;
    logic        Reset;
    logic        round_start;
    logic [3:0]  hit;
    logic [3:0]  hit_tgt;
    logic [31:0] hit_dmg;
    logic [7:0]  hp1;
    logic [7:0]  hp2;
    logic [3:0]  hit_ack;
    logic [1:0]  phase;
    logic [1:0]  winner;

    damage_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .round_start (round_start),
        .hit         (hit),
        .hit_tgt     (hit_tgt),
        .hit_dmg     (hit_dmg),
        .hp1         (hp1),
        .hp2         (hp2),
        .hit_ack     (hit_ack),
        .phase       (phase),
        .winner      (winner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] hp1;
        logic [7:0] hp2;
        logic [1:0] ph;
        logic [1:0] win;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   drv_done = 0;

    // Reference model state: phase 0 idle, 1 active, 2 ko; winner 0/1/2.
    int       m_phase, m_hp1, m_hp2, m_win, m_rr;
    bit [3:0] m_pend, m_tgt, m_hq;
    int       m_dmg [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_hp1 = HP; m_hp2 = HP; m_win = 0; m_rr = 0;
        m_pend = 0; m_tgt = 0; m_hq = 0;
        for (int i = 0; i < 4; i++) m_dmg[i] = 0;
    endtask

    task automatic model_step(input logic rs, input logic [3:0] h, input logic [3:0] t,
                              input logic [31:0] d, input bit rst, output logic [3:0] ack);
        int g, dm, hpv, tg;
        logic [3:0] rise, old;
        g = -1; hpv = -1; tg = 0; ack = 4'b0;
        rise = h & ~m_hq;
        old  = m_pend;
        if (m_phase == 1 && !rs) begin
            for (int k = 0; k < 4; k++)
                if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        end
        if (g >= 0) ack[g] = 1'b1;
        if (rst) begin
            model_reset();
            return;
        end
        m_hq = h;
        if (rs) begin
            m_hp1 = HP; m_hp2 = HP; m_pend = 0; m_win = 0; m_rr = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % 4;
                dm = m_dmg[g];
                tg = int'(m_tgt[g]);
                if (tg == 1) begin
                    m_hp2 = (m_hp2 > dm) ? m_hp2 - dm : 0;
                    hpv = m_hp2;
                end else begin
                    m_hp1 = (m_hp1 > dm) ? m_hp1 - dm : 0;
                    hpv = m_hp1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (rise[i] && (!old[i] || i == g)) begin
                    m_pend[i] = 1'b1;
                    m_tgt[i]  = t[i];
                    m_dmg[i]  = int'(d[8*i +: 8]);
                end
            end
            if (hpv == 0) begin
                m_phase = 2;
                m_win = (tg == 1) ? 1 : 2;
                m_pend = 0;
            end
        end
    endtask

    // mode 0: normal cycle, 1: Reset held for the cycle, 2: Reset asserted mid-cycle.
    task automatic cyc(input logic rs, input logic [3:0] h, input logic [3:0] t,
                       input logic [31:0] d, input int mode);
        logic [3:0] a;
        @(negedge Clk);
        round_start = rs;
        hit         = h;
        hit_tgt     = t;
        hit_dmg     = d;
        Reset       = (mode == 1);
        model_step(rs, h, t, d, mode != 0, a);
        exp_q.push_back('{a, 8'(m_hp1), 8'(m_hp2), 2'(m_phase), 2'(m_win)});
        if (mode == 2) begin
            #3 Reset = 1'b1;
            #1;
            chk("async_rst_hp1", hp1, HP);
            chk("async_rst_hp2", hp2, HP);
            chk("async_rst_phase", phase, 0);
            chk("async_rst_winner", winner, 0);
            chk("async_rst_ack", hit_ack, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; round_start = 1'b0; hit = 4'b0; hit_tgt = 4'b0; hit_dmg = 32'b0;
        model_reset();
        fork
            begin : driver
                logic [3:0]  rh, rt;
                logic [31:0] rd;
                logic        rs;
                int          mode, next_mode;
                cyc(0, 4'b0, 4'b0, 32'd0, 1);
                cyc(0, 4'b0, 4'b0, 32'd0, 1);
                // Single hit on player 2.
                cyc(1, 4'b0, 4'b0, 32'd0, 0);
                repeat (5) cyc(0, 4'b0001, 4'b0001, 32'd10, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                chk("single_hit_hp2", hp2, 240);
                chk("single_hit_hp1", hp1, 250);
                // Four simultaneous rises served in order.
                cyc(1, 4'b0, 4'b0, 32'd0, 0);
                repeat (6) cyc(0, 4'hF, 4'h0, {8'd4, 8'd3, 8'd2, 8'd1}, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                chk("contention_hp1", hp1, 240);
                // Drive player 2 to 15, then KO with 20.
                cyc(1, 4'b0, 4'b0, 32'd0, 0);
                cyc(0, 4'b0001, 4'b0001, 32'd235, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                chk("pre_ko_hp2", hp2, 15);
                cyc(0, 4'b0100, 4'b0100, {8'd0, 8'd20, 8'd0, 8'd0}, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                chk("ko_hp2", hp2, 0);
                chk("ko_phase", phase, 2);
                chk("ko_winner", winner, 1);
                cyc(0, 4'hF, 4'h0, 32'h0101_0101, 0);
                cyc(0, 4'hF, 4'h0, 32'h0101_0101, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                // Restart from KO with hit[1] held high.
                cyc(0, 4'b0010, 4'b0, 32'h0000_0500, 0);
                cyc(1, 4'b0010, 4'b0, 32'h0000_0500, 0);
                repeat (3) cyc(0, 4'b0010, 4'b0, 32'h0000_0500, 0);
                chk("restart_phase", phase, 1);
                chk("restart_hp1", hp1, 250);
                chk("restart_hp2", hp2, 250);
                chk("restart_winner", winner, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                cyc(0, 4'b0010, 4'b0, 32'h0000_0500, 0);
                cyc(0, 4'b0010, 4'b0, 32'h0000_0500, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                // Re-rise on a pending source keeps the original damage.
                cyc(1, 4'b0, 4'b0, 32'd0, 0);
                cyc(0, 4'b0010, 4'b0, {8'd1, 8'd2, 8'd7, 8'd5}, 0);
                cyc(0, 4'b1111, 4'b0, {8'd1, 8'd2, 8'd7, 8'd5}, 0);
                cyc(0, 4'b1110, 4'b0, {8'd1, 8'd2, 8'd7, 8'd5}, 0);
                cyc(0, 4'b1111, 4'b0, {8'd1, 8'd2, 8'd7, 8'd50}, 0);
                cyc(0, 4'b1111, 4'b0, {8'd1, 8'd2, 8'd7, 8'd50}, 0);
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                chk("rerise_hp1", hp1, 235);
                // Async reset with three hits pending.
                cyc(1, 4'b0, 4'b0, 32'd0, 0);
                cyc(0, 4'b0111, 4'b0, 32'h0001_0101, 0);
                cyc(0, 4'b0111, 4'b0, 32'h0001_0101, 2);
                cyc(0, 4'b0111, 4'b0, 32'h0001_0101, 1);
                repeat (3) cyc(0, 4'b0111, 4'b0, 32'h0001_0101, 0);
                chk("post_rst_phase", phase, 0);
                // Random traffic.
                rh = 4'b0;
                next_mode = 0;
                for (int n = 0; n < 1500; n++) begin
                    mode = next_mode;
                    next_mode = 0;
                    if (mode == 0 && $urandom_range(0, 299) == 0) begin
                        mode = 2;
                        next_mode = 1;
                    end
                    rs = (m_phase != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
                    for (int b = 0; b < 4; b++)
                        if ($urandom_range(0, 2) == 0) rh[b] = ~rh[b];
                    rt = 4'($urandom);
                    for (int b = 0; b < 4; b++) rd[8*b +: 8] = 8'($urandom_range(0, 60));
                    cyc(rs, rh, rt, rd, mode);
                end
                cyc(0, 4'b0, 4'b0, 32'd0, 0);
                @(negedge Clk);
                drv_done = 1;
            end
            begin : monitor
                exp_t e;
                while (1) begin
                    @(negedge Clk);
                    #2;
                    if (exp_q.size() == 0) begin
                        if (drv_done) break;
                        continue;
                    end
                    e = exp_q.pop_front();
                    chk("hit_ack", hit_ack, e.ack);
                    @(posedge Clk);
                    #1;
                    chk("hp1", hp1, e.hp1);
                    chk("hp2", hp2, e.hp2);
                    chk("phase", phase, e.ph);
                    chk("winner", winner, e.win);
                end
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
